// File: rtl/motoro3_ramp_ctrl.sv
// motoro3_ramp_ctrl: align / ramp / run / decelerate sequencer feeding a commutation engine.
// Optional stall watchdog compiled in when M3RAMP_STALL_DET_EN is defined.
module motoro3_ramp_ctrl #(
    parameter logic [24:0] START_PERIOD = 25'd1_666_667,
    parameter logic [24:0] MIN_PERIOD   = 25'd1_667,
    parameter logic [23:0] ALIGN_CYC    = 24'd10_000_000,
    parameter int unsigned DEC_SHIFT    = 4
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        run_req,
    input  logic        abort,
    input  logic [24:0] tgt_period,
    input  logic [3:0]  step_in,
    output logic        m3start,
    output logic [24:0] m3period,
    output logic [2:0]  state,
    output logic        at_speed,
    output logic        busy,
    output logic        fault
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        DECEL = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] period_q, period_d;
    logic [23:0] align_cnt_q, align_cnt_d;
    logic [3:0]  prev_step_q;
    logic [24:0] eff_tgt;
    logic [25:0] per_ext, tgt_ext, dec_step, run_step;
    logic [25:0] ramp_next, run_dn, run_up, decel_sum;
    logic        wrap;

    function automatic logic [24:0] sat25(input logic [25:0] v);
        return v[25] ? '1 : v[24:0];
    endfunction

    always_comb begin
        if (tgt_period < MIN_PERIOD)
            eff_tgt = MIN_PERIOD;
        else if (tgt_period > START_PERIOD)
            eff_tgt = START_PERIOD;
        else
            eff_tgt = tgt_period;
    end

    assign wrap = (step_in == 4'd1) && (prev_step_q == 4'd6);

    // All candidate periods are formed one bit wider so add/sub cannot wrap.
    always_comb begin
        per_ext   = {1'b0, period_q};
        tgt_ext   = {1'b0, eff_tgt};
        dec_step  = per_ext >> DEC_SHIFT;
        run_step  = (dec_step == '0) ? 26'd1 : dec_step;
        ramp_next = per_ext - dec_step;
        if (ramp_next < tgt_ext)
            ramp_next = tgt_ext;
        run_dn = per_ext - run_step;
        if (run_dn < tgt_ext)
            run_dn = tgt_ext;
        run_up = per_ext + run_step;
        if (run_up > tgt_ext)
            run_up = tgt_ext;
        decel_sum = per_ext + dec_step;
    end

`ifdef M3RAMP_STALL_DET_EN
    logic [26:0] stall_cnt_q, stall_cnt_d, stall_lim;
    logic        monitoring, stall_hit;

    // >= rather than == so a shrinking period cannot skip past the limit.
    always_comb begin
        stall_lim   = {1'b0, period_q, 1'b0} + 27'd16;
        monitoring  = (state_q == RAMP) || (state_q == RUN) || (state_q == DECEL);
        stall_hit   = monitoring && (step_in == prev_step_q) && (stall_cnt_q >= stall_lim - 27'd1);
        stall_cnt_d = (monitoring && (step_in == prev_step_q)) ? stall_cnt_q + 27'd1 : '0;
    end
`endif

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        align_cnt_d = align_cnt_q;
        if (abort) begin
            state_d  = IDLE;
            period_d = START_PERIOD;
        end
`ifdef M3RAMP_STALL_DET_EN
        else if (stall_hit) begin
            state_d = FAULT;
        end
`endif
        else begin
            case (state_q)
                IDLE: begin
                    period_d = START_PERIOD;
                    if (run_req) begin
                        state_d     = ALIGN;
                        align_cnt_d = '0;
                    end
                end
                ALIGN: begin
                    if (!run_req)
                        state_d = IDLE;
                    else if (align_cnt_q == ALIGN_CYC - 24'd1)
                        state_d = RAMP;
                    else
                        align_cnt_d = align_cnt_q + 24'd1;
                end
                RAMP: begin
                    if (!run_req)
                        state_d = DECEL;
                    else if (wrap) begin
                        period_d = sat25(ramp_next);
                        if (ramp_next == tgt_ext)
                            state_d = RUN;
                    end
                end
                RUN: begin
                    if (!run_req)
                        state_d = DECEL;
                    else if (wrap) begin
                        if (per_ext > tgt_ext)
                            period_d = sat25(run_dn);
                        else if (per_ext < tgt_ext)
                            period_d = sat25(run_up);
                    end
                end
                DECEL: begin
                    if (run_req)
                        state_d = RAMP;
                    else if (wrap) begin
                        if (decel_sum >= {1'b0, START_PERIOD}) begin
                            state_d  = IDLE;
                            period_d = START_PERIOD;
                        end else begin
                            period_d = sat25(decel_sum);
                        end
                    end
                end
                FAULT: begin
                    if (!run_req) begin
                        state_d  = IDLE;
                        period_d = START_PERIOD;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    period_d = START_PERIOD;
                end
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (!nRst) begin
            state_q     <= IDLE;
            period_q    <= START_PERIOD;
            align_cnt_q <= '0;
            prev_step_q <= '0;
`ifdef M3RAMP_STALL_DET_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            align_cnt_q <= align_cnt_d;
            prev_step_q <= step_in;
`ifdef M3RAMP_STALL_DET_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    always_comb begin
        state    = state_q;
        m3period = period_q;
        m3start  = (state_q == ALIGN) || (state_q == RAMP) || (state_q == RUN) || (state_q == DECEL);
        at_speed = (state_q == RUN) && (period_q == eff_tgt);
        busy     = (state_q != IDLE);
`ifdef M3RAMP_STALL_DET_EN
        fault    = (state_q == FAULT);
`else
        fault    = 1'b0;
`endif
    end
endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Bench for motoro3_ramp_ctrl: directed vector table, then random stimulus vs a behavioural model.
module tb_motoro3_ramp_ctrl;
    localparam logic [24:0] SP = 25'd64;
    localparam logic [24:0] MP = 25'd8;
    localparam logic [23:0] AC = 24'd100;
    localparam int unsigned DS = 2;

    logic        clk = 1'b0;
    logic        nRst, run_req, abort;
    logic [24:0] tgt_period;
    logic [3:0]  step_in;
    logic        m3start, at_speed, busy, fault;
    logic [24:0] m3period;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    motoro3_ramp_ctrl #(
        .START_PERIOD(SP),
        .MIN_PERIOD(MP),
        .ALIGN_CYC(AC),
        .DEC_SHIFT(DS)
    ) dut (
        .clk(clk), .nRst(nRst), .run_req(run_req), .abort(abort),
        .tgt_period(tgt_period), .step_in(step_in),
        .m3start(m3start), .m3period(m3period), .state(state),
        .at_speed(at_speed), .busy(busy), .fault(fault)
    );

    always #50 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // DUT state moves on the falling edge; outputs are sampled on the rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    typedef struct {
        int    kind;   // 0 plain cycle, 1 wrap, 2 wait out align, 3 reset pulse
        bit    run;
        bit    ab;
        int    tgt;
        int    e_st;
        int    e_p;
        bit    e_start;
        bit    e_at;
        string name;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(int kind, bit run, bit ab, int tgt, int e_st, int e_p,
                               bit e_start, bit e_at, string name);
        vec_t r;
        r.kind = kind; r.run = run; r.ab = ab; r.tgt = tgt; r.e_st = e_st;
        r.e_p = e_p; r.e_start = e_start; r.e_at = e_at; r.name = name;
        return r;
    endfunction

    task automatic apply(input vec_t x);
        int n;
        case (x.kind)
            1: begin
                run_req = x.run; tgt_period = 25'(x.tgt); abort = 1'b0; step_in = 4'd6;
                tick();
                abort = x.ab; step_in = 4'd1;
                tick();
            end
            2: begin
                run_req = x.run; tgt_period = 25'(x.tgt); abort = x.ab;
                tick();
                n = 0;
                while (state == 3'd1 && n < 300) begin
                    n++;
                    tick();
                end
                chk({x.name, "_len"}, 32'(n), 32'd100);
            end
            3: begin
                nRst = 1'b0; run_req = x.run; tgt_period = 25'(x.tgt); abort = x.ab;
                tick();
                nRst = 1'b1;
            end
            default: begin
                run_req = x.run; tgt_period = 25'(x.tgt); abort = x.ab;
                tick();
            end
        endcase
        chk({x.name, "_state"}, 32'(state), 32'(x.e_st));
        chk({x.name, "_period"}, 32'(m3period), 32'(x.e_p));
        chk({x.name, "_start"}, 32'(m3start), 32'(x.e_start));
        chk({x.name, "_atspd"}, 32'(at_speed), 32'(x.e_at));
        chk({x.name, "_busy"}, 32'(busy), 32'(x.e_st != 0));
        chk({x.name, "_fault"}, 32'(fault), 32'd0);
    endtask

    // Behavioural reference: the documented rules in plain integer arithmetic.
    int m_st, m_p, m_cnt, m_prev;

    function automatic int clampt(int t);
        if (t < int'(MP)) return int'(MP);
        if (t > int'(SP)) return int'(SP);
        return t;
    endfunction

    task automatic model_edge();
        int t, np, s, div;
        bit w;
        div = 1 << DS;
        t = clampt(int'(tgt_period));
        w = (int'(step_in) == 1) && (m_prev == 6);
        if (!nRst) begin
            m_st = 0; m_p = int'(SP); m_cnt = 0; m_prev = 0;
            return;
        end
        if (abort) begin
            m_st = 0; m_p = int'(SP);
        end else begin
            case (m_st)
                0: begin
                    m_p = int'(SP);
                    if (run_req) begin m_st = 1; m_cnt = 0; end
                end
                1: begin
                    if (!run_req) m_st = 0;
                    else if (m_cnt == int'(AC) - 1) m_st = 2;
                    else m_cnt++;
                end
                2: begin
                    if (!run_req) m_st = 4;
                    else if (w) begin
                        np = m_p - m_p / div;
                        if (np < t) np = t;
                        m_p = np;
                        if (np == t) m_st = 3;
                    end
                end
                3: begin
                    if (!run_req) m_st = 4;
                    else if (w) begin
                        s = (m_p / div > 1) ? m_p / div : 1;
                        if (m_p > t) m_p = (m_p - s < t) ? t : m_p - s;
                        else if (m_p < t) m_p = (m_p + s > t) ? t : m_p + s;
                    end
                end
                4: begin
                    if (run_req) m_st = 2;
                    else if (w) begin
                        if (m_p + m_p / div >= int'(SP)) begin m_st = 0; m_p = int'(SP); end
                        else m_p = m_p + m_p / div;
                    end
                end
                default: m_st = 0;
            endcase
        end
        m_prev = int'(step_in);
    endtask

    initial begin
        nRst = 1'b0; run_req = 1'b0; abort = 1'b0; tgt_period = 25'd16; step_in = 4'd0;

        vt.push_back(v(3, 0, 0, 16, 0, 64, 0, 0, "reset"));
        vt.push_back(v(2, 1, 0, 16, 2, 64, 1, 0, "align"));
        vt.push_back(v(1, 1, 0, 16, 2, 48, 1, 0, "ramp48"));
        vt.push_back(v(1, 1, 0, 16, 2, 36, 1, 0, "ramp36"));
        vt.push_back(v(1, 1, 0, 16, 2, 27, 1, 0, "ramp27"));
        vt.push_back(v(1, 1, 0, 16, 2, 21, 1, 0, "ramp21"));
        vt.push_back(v(1, 1, 0, 16, 3, 16, 1, 1, "ramp16"));
        vt.push_back(v(0, 1, 0, 16, 3, 16, 1, 1, "run_hold"));
        vt.push_back(v(1, 1, 0, 24, 3, 20, 1, 0, "up20"));
        vt.push_back(v(1, 1, 0, 24, 3, 24, 1, 1, "up24"));
        vt.push_back(v(1, 1, 0, 16, 3, 18, 1, 0, "dn18"));
        vt.push_back(v(1, 1, 0, 16, 3, 16, 1, 1, "dn16"));
        vt.push_back(v(0, 0, 0, 16, 4, 16, 1, 0, "decel"));
        vt.push_back(v(1, 0, 0, 16, 4, 20, 1, 0, "dec20"));
        vt.push_back(v(1, 0, 0, 16, 4, 25, 1, 0, "dec25"));
        vt.push_back(v(1, 0, 0, 16, 4, 31, 1, 0, "dec31"));
        vt.push_back(v(1, 0, 0, 16, 4, 38, 1, 0, "dec38"));
        vt.push_back(v(1, 0, 0, 16, 4, 47, 1, 0, "dec47"));
        vt.push_back(v(1, 0, 0, 16, 4, 58, 1, 0, "dec58"));
        vt.push_back(v(1, 0, 0, 16, 0, 64, 0, 0, "dec_idle"));
        vt.push_back(v(2, 1, 0, 4, 2, 64, 1, 0, "align_lo"));
        vt.push_back(v(1, 1, 0, 4, 2, 48, 1, 0, "lo48"));
        vt.push_back(v(1, 1, 0, 4, 2, 36, 1, 0, "lo36"));
        vt.push_back(v(1, 1, 0, 4, 2, 27, 1, 0, "lo27"));
        vt.push_back(v(1, 1, 0, 4, 2, 21, 1, 0, "lo21"));
        vt.push_back(v(1, 1, 0, 4, 2, 16, 1, 0, "lo16"));
        vt.push_back(v(1, 1, 0, 4, 2, 12, 1, 0, "lo12"));
        vt.push_back(v(1, 1, 0, 4, 2, 9, 1, 0, "lo9"));
        vt.push_back(v(1, 1, 0, 4, 3, 8, 1, 1, "clamp_lo"));
        vt.push_back(v(0, 0, 0, 4, 4, 8, 1, 0, "decel2"));
        vt.push_back(v(1, 0, 0, 4, 4, 10, 1, 0, "dec10"));
        vt.push_back(v(0, 1, 0, 4, 2, 10, 1, 0, "reramp"));
        vt.push_back(v(1, 1, 0, 4, 3, 8, 1, 1, "reramp8"));
        vt.push_back(v(0, 1, 1, 4, 0, 64, 0, 0, "abort_run"));
        vt.push_back(v(2, 1, 0, 16, 2, 64, 1, 0, "align_ab"));
        vt.push_back(v(1, 1, 0, 16, 2, 48, 1, 0, "ab48"));
        vt.push_back(v(1, 1, 1, 16, 0, 64, 0, 0, "abort_wrap"));
        vt.push_back(v(2, 1, 0, 100, 2, 64, 1, 0, "align_hi"));
        vt.push_back(v(1, 1, 0, 100, 3, 64, 1, 1, "clamp_hi"));
        vt.push_back(v(1, 1, 0, 16, 3, 48, 1, 0, "tgt_dn"));
        vt.push_back(v(0, 0, 0, 16, 4, 48, 1, 0, "decel3"));
        vt.push_back(v(3, 0, 0, 16, 0, 64, 0, 0, "rst_mid"));
        vt.push_back(v(0, 1, 0, 16, 1, 64, 1, 0, "align_in"));
        vt.push_back(v(0, 0, 0, 16, 0, 64, 0, 0, "align_drop"));

        foreach (vt[i]) apply(vt[i]);

        // Random phase against the reference model.
        nRst = 1'b0; abort = 1'b0; run_req = 1'b1; tgt_period = 25'd16; step_in = 4'd1;
        tick();
        model_edge();
        nRst = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            int r;
            nRst  = ($urandom_range(0, 1499) != 0);
            abort = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) run_req = ~run_req;
            if ($urandom_range(0, 99) == 0) tgt_period = 25'($urandom_range(0, 120));
            r = $urandom_range(0, 15);
            if (r < 10) step_in = (step_in == 4'd0 || step_in >= 4'd6) ? 4'd1 : step_in + 4'd1;
            else if (r < 12) step_in = 4'($urandom_range(0, 7));
            tick();
            model_edge();
            chk("rnd_state", 32'(state), 32'(m_st));
            chk("rnd_period", 32'(m3period), 32'(m_p));
            chk("rnd_start", 32'(m3start), 32'(m_st >= 1 && m_st <= 4));
            chk("rnd_atspd", 32'(at_speed), 32'(m_st == 3 && m_p == clampt(int'(tgt_period))));
            chk("rnd_busy", 32'(busy), 32'(m_st != 0));
            chk("rnd_fault", 32'(fault), 32'd0);
        end

`ifdef M3RAMP_STALL_DET_EN
        begin
            int n;
            nRst = 1'b0; abort = 1'b0; run_req = 1'b1; tgt_period = 25'd16; step_in = 4'd1;
            tick();
            nRst = 1'b1;
            n = 0;
            while (!(state == 3'd3 && m3period == 25'd16) && n < 2000) begin
                step_in = (step_in >= 4'd6) ? 4'd1 : step_in + 4'd1;
                tick();
                n++;
            end
            chk("stall_reach_run", 32'(state), 32'd3);
            n = 0;
            while (!fault && n < 200) begin
                tick();
                n++;
            end
            chk("stall_fault", 32'(fault), 32'd1);
            chk("stall_start", 32'(m3start), 32'd0);
            chk("stall_window", 32'(n >= 44 && n <= 52), 32'd1);
            run_req = 1'b0;
            tick();
            chk("stall_exit", 32'(state), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
